// File: rtl/lab_3_dec_to_bin.sv
// Sequential decimal-to-binary entry block.
// The operator keys BCD digits on SW with KEY[0]; digits accumulate into a binary value and are
// echoed on HEX3..HEX0 (HEX0 = newest digit). KEY[2] commits the value to LEDR with a one-cycle
// valid pulse; KEY[1] clears the entry. An invalid digit or a digit beyond MAX_DIGITS locks the
// block in an error state until it is cleared.
// Ports:
//   CLOCK_50    : system clock, rising edge
//   reset       : asynchronous, active-high
//   SW[3:0]     : BCD digit to enter
//   KEY[2:0]    : active-low buttons (0 enter, 1 clear, 2 commit)
//   HEX3..HEX0  : active-low seven-segment outputs
//   LEDR        : committed binary value
//   valid       : one-cycle pulse when LEDR is updated by a commit
//   err         : high while in the error state
//   count       : number of digits currently held
module lab_3_dec_to_bin #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned WIDTH      = 14
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [3:0]       SW,
  input  logic [2:0]       KEY,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [WIDTH-1:0] LEDR,
  output logic             valid,
  output logic             err,
  output logic [2:0]       count
);

  localparam logic [2:0] MaxCount = 3'(MAX_DIGITS);
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegE     = 7'b0000110;

  typedef enum logic [1:0] {StIdle, StEntry, StError} state_e;

  // Key synchronizer and falling-edge detector.
  logic [2:0] key_s1_q, key_s2_q, key_prev_q, strobe_q;
  logic [1:0] settle_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1_q   <= 3'b111;
      key_s2_q   <= 3'b111;
      key_prev_q <= 3'b000;
      strobe_q   <= 3'b000;
      settle_q   <= 2'd0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      // Until key_s2_q holds a real sample, the previous value is forced low so that a key
      // already held at reset release never looks like a fresh press.
      key_prev_q <= (settle_q == 2'd2) ? key_s2_q : 3'b000;
      strobe_q   <= key_prev_q & ~key_s2_q;
    end
  end

  logic enter_s, clear_s, commit_s;
  assign enter_s  = strobe_q[0];
  assign clear_s  = strobe_q[1];
  assign commit_s = strobe_q[2];

  // Entry state.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       count_q, count_d;
  logic [3:0][3:0]  digits_q, digits_d;  // digits_q[0] is the newest digit
  logic [WIDTH-1:0] led_q, led_d;
  logic             valid_q, valid_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      count_q  <= 3'd0;
      digits_q <= '0;
      led_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      digits_q <= digits_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    digits_d = digits_q;
    led_d    = led_q;
    valid_d  = 1'b0;
    if (clear_s) begin
      state_d  = StIdle;
      acc_d    = '0;
      count_d  = 3'd0;
      digits_d = '0;
    end else if (enter_s) begin
      // A commit in the same cycle is dropped.
      if (state_q != StError) begin
        if (SW > 4'd9 || count_q == MaxCount) begin
          state_d = StError;
        end else begin
          // acc * 10 + SW; acc < 10^(MAX_DIGITS-1) here, so nothing is lost.
          acc_d    = (acc_q << 3) + (acc_q << 1) + WIDTH'(SW);
          count_d  = count_q + 3'd1;
          digits_d = {digits_q[2:0], SW};
          state_d  = StEntry;
        end
      end
    end else if (commit_s && state_q != StError) begin
      led_d    = acc_q;
      valid_d  = 1'b1;
      acc_d    = '0;
      count_d  = 3'd0;
      digits_d = '0;
      state_d  = StIdle;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SegBlank;
    endcase
  endfunction

  logic [3:0][6:0] hex;

  always_comb begin
    hex = {4{SegBlank}};
    if (state_q == StError) begin
      hex[0] = SegE;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < count_q) hex[i] = seg7(digits_q[i]);
      end
    end
  end

  assign HEX0  = hex[0];
  assign HEX1  = hex[1];
  assign HEX2  = hex[2];
  assign HEX3  = hex[3];
  assign LEDR  = led_q;
  assign valid = valid_q;
  assign err   = (state_q == StError);
  assign count = count_q;

endmodule

// File: doc/lab_3_dec_to_bin.md
# lab_3_dec_to_bin

Sequential decimal-to-binary entry block: the operator keys decimal digits one at a time on SW[3:0]/KEY, and the block accumulates them into a binary value. Entered digits are echoed on the four seven-segment displays using the same active-low segment encoding as the binary-to-decimal display path. On commit, the accumulated value is presented on LEDR. It is the input-side counterpart of the bin-to-dec display logic and sits directly on the board switches, keys, HEX and LEDs.

## Interface
- MAX_DIGITS, 4, maximum digits accepted per number (value range 0..9999)
- WIDTH, 14, width of the binary result (must hold 10^MAX_DIGITS − 1)

- CLOCK_50  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; one clock, no other clock domains
- SW  input  4  BCD digit to enter
- KEY  input  3  active-low push buttons: KEY[0] enter digit, KEY[1] clear, KEY[2] commit
- HEX3..HEX0  output  7 each  active-low segments; HEX0 = most recently entered digit
- LEDR  output  WIDTH  committed binary value
- valid  output  1  one-cycle pulse when LEDR is updated by a commit
- err  output  1  high while in ERROR state
- count  output  3  number of digits currently held (0..MAX_DIGITS)

## Operation
- Each KEY bit passes through a 2-flop synchronizer and then a falling-edge detector. This produces a one-cycle strobe per press: enter_s, clear_s, commit_s. There is no debounce; the bench drives clean edges.
- States: IDLE (count=0), ENTRY (1..MAX_DIGITS digits held), ERROR.
- Strobe priority within one cycle: clear > enter > commit. A commit that coincides with an enter is dropped.
- clear_s, in any state: acc←0, count←0, digit buffer blanked, go to IDLE. LEDR is unchanged.
- enter_s in IDLE or ENTRY:
  - SW>9: go to ERROR; acc and count are held.
  - count==MAX_DIGITS: go to ERROR (overflow).
  - otherwise: acc←acc*10+SW, computed as (acc<<3)+(acc<<1)+SW at WIDTH bits with no truncation possible. count←count+1, digit buffer shifts left (HEX3 ← HEX2 … HEX0 ← SW), go to ENTRY.
- commit_s in IDLE or ENTRY: LEDR←acc, valid=1 for one cycle, acc←0, count←0, buffer blanked, go to IDLE. Commit in IDLE yields LEDR=0 with valid pulse.
- In ERROR, enter_s and commit_s are ignored. Only clear_s or reset exits ERROR.
- Display:
  - Digit positions ≥ count are blank (7'b1111111).
  - Held digits use the encoding 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000.
  - In ERROR: HEX0=7'b0000110 ("E"), HEX3..HEX1 blank.
- HEX outputs are decoded from registered state, so no latches are inferred and every case has a default.

## Timing
- Reset values: state=IDLE, acc=0, count=0, LEDR=0, valid=0, err=0, HEX3..HEX0=7'b1111111. Synchronizer flops reset to 1 (key released).
- Key latency: a KEY falling edge sampled at rising edge n gives a strobe high during cycle n+2. State, acc, count, HEX, LEDR and valid update at rising edge n+3.
- A key held low produces exactly one strobe. A key must return high for ≥2 cycles before the next press is recognised.
- valid is high for exactly one cycle per accepted commit, never in back-to-back cycles from one press.
- Reset asserted mid-entry clears everything immediately (asynchronously), including in-flight synchronizer state. No strobe is generated from a key already low at reset release until it is released and pressed again.
- SW is sampled in the cycle enter_s is high and must be stable from the KEY edge until the update.

## Test plan
- Reset, then enter 1,2,3,4, then commit: LEDR=1234 (0x4D2), valid one cycle, count returns to 0, HEX all blank. Before commit, HEX3..0 showed 1,2,3,4.
- Enter 9 four times, commit: LEDR=9999. Then enter a 5th digit before commit on a fresh 9999: err=1, HEX0="E", count stays 4. A following commit is ignored (LEDR unchanged, no valid). Clear: IDLE, err=0.
- Enter SW=4'hA: err=1, acc unchanged. Then clear and enter 7, commit: LEDR=7.
- Commit with no digits: LEDR=0, valid pulse. Enter 5 and commit in the same cycle: digit accepted (count=1, HEX0="5"), no valid pulse.
- Enter 3,8, assert reset mid-sequence: all outputs at reset values. Pressing KEY[1] and KEY[0] together: clear wins, count=0.
- Hold KEY[0] low for 20 cycles with SW=6: exactly one digit entered (count=1). Leading zeros: enter 0,0,5, commit → LEDR=5, HEX showed blank,0,0,5 before commit.
